// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  // Which writeback requester owns the write port (or the round-robin pointer).
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef logic [AW-1:0] reg_idx_t;

  // One writeback request as it travels to the write stage register.
  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter (ALU vs LSU) with ready generation and pointer.
// Latency: combinational grant; pointer advances on the edge after a grant.
// Backpressure: a side's ready drops only when the other side is valid and owns the pointer.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_valid,
  input  logic    lsu_valid,
  output logic    alu_ready,
  output logic    lsu_ready,
  output logic    alu_gnt,
  output logic    lsu_gnt
);

  wb_src_e rr;

  // Ready never looks at its own valid, so a requester may wait on ready before asserting valid.
  // Both readies are held low while reset is asserted.
  assign alu_ready = rst_n & ~(lsu_valid & (rr == WB_LSU));
  assign lsu_ready = rst_n & ~(alu_valid & (rr == WB_ALU));
  assign alu_gnt   = alu_valid & alu_ready;
  assign lsu_gnt   = lsu_valid & lsu_ready;

  // Point away from whoever was just granted so contention alternates every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= WB_ALU;
    end else if (alu_gnt) begin
      rr <= WB_LSU;
    end else if (lsu_gnt) begin
      rr <= WB_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: ALU/LSU writeback arbitration plus pending-write scoreboard.
// Latency: grant in cycle N drives rf_we/rf_a3/rf_wd in N+1; busy clears at the end of N+1.
// Backpressure: losing writeback side sees ready=0 for one cycle; issue stalls while rd is busy.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            alu_gnt;
  logic            lsu_gnt;
  logic            wr_gnt;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  logic            reserve;

  wb_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .alu_ready (alu_ready),
    .lsu_ready (lsu_ready),
    .alu_gnt   (alu_gnt),
    .lsu_gnt   (lsu_gnt)
  );

  // busy_q[0] is never set, so indexing with x0 always reads 0.
  assign iss_ready = rst_n & ~busy_q[iss_rd];
  assign rs1_busy  = busy_q[rs1_addr];
  assign rs2_busy  = busy_q[rs2_addr];
  assign reserve   = iss_valid & iss_ready & (iss_rd != '0);

  // At most one side is granted, so a simple select picks the winning request.
  assign wr_gnt  = alu_gnt | lsu_gnt;
  assign wr_rd   = lsu_gnt ? lsu_rd   : alu_rd;
  assign wr_data = lsu_gnt ? lsu_data : alu_data;

  // Next scoreboard: retire clears first, then a same-edge reservation re-sets it.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) begin
      busy_d[rf_a3] = 1'b0;
    end
    if (reserve) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard and write stage register; reset kills any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      rf_we  <= 1'b0;
      rf_a3  <= '0;
      rf_wd  <= '0;
    end else begin
      busy_q <= busy_d;
      rf_we  <= wr_gnt & (wr_rd != '0);
      if (wr_gnt) begin
        rf_a3 <= wr_rd;
        rf_wd <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, scoreboard, arbitration, x0, WAW stall, set-wins, mid-run reset.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: drives ALU/LSU streams and holds a request until its ready is seen.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            iss_valid;
  reg_idx_t        iss_rd;
  logic            iss_ready;
  reg_idx_t        rs1_addr;
  reg_idx_t        rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            alu_valid;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  reg_idx_t        lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  reg_idx_t        rf_a3;
  logic [XLEN-1:0] rf_wd;

  int total;
  int bad;

  regfile_wb_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    cyc(); cyc();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    total++; if (rf_a3 !== 5'd0) begin bad++; $display("FAIL reset_rf_a3 got=%0d exp=0", rf_a3); end
    total++; if (rf_wd !== 32'h0) begin bad++; $display("FAIL reset_rf_wd got=%h exp=0", rf_wd); end
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL reset_iss_ready got=%b exp=0", iss_ready); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL post_reset_iss_ready got=%b exp=1", iss_ready); end
    total++; if ({alu_ready, lsu_ready} !== 2'b11) begin bad++; $display("FAIL post_reset_readies got=%b exp=11", {alu_ready, lsu_ready}); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL post_reset_rs1_busy got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_basic_write();
    iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
    #1;
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL basic_iss_ready got=%b exp=1", iss_ready); end
    cyc();
    iss_valid = 1'b0;
    #1;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL basic_busy5_set got=%b exp=1", rs1_busy); end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL basic_alu_ready got=%b exp=1", alu_ready); end
    cyc();
    alu_valid = 1'b0;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL basic_rf_we got=%b exp=1", rf_we); end
    total++; if (rf_a3 !== 5'd5) begin bad++; $display("FAIL basic_rf_a3 got=%0d exp=5", rf_a3); end
    total++; if (rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rf_wd got=%h exp=deadbeef", rf_wd); end
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_during_retire got=%b exp=1", rs1_busy); end
    cyc();
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL basic_busy5_clear got=%b exp=0", rs1_busy); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL basic_rf_we_drop got=%b exp=0", rf_we); end
    total++; if (rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rf_wd_hold got=%h exp=deadbeef", rf_wd); end
  endtask

  task automatic test_contention();
    int ai;
    int li;
    logic exp_alu;
    logic [4:0] exp_rd;
    logic [31:0] exp_wd;
    pulse_reset();
    ai = 0; li = 0;
    for (int k = 0; k < 8; k++) begin
      alu_valid = (ai < 4);
      alu_rd    = 5'(1 + ai);
      alu_data  = 32'hA000_0000 + 32'(ai);
      lsu_valid = (li < 4);
      lsu_rd    = 5'(11 + li);
      lsu_data  = 32'hB000_0000 + 32'(li);
      exp_alu   = ((k % 2) == 0);
      #1;
      total++; if ({alu_ready, lsu_ready} !== {exp_alu, ~exp_alu}) begin
        bad++; $display("FAIL rr_readies k=%0d got=%b exp=%b", k, {alu_ready, lsu_ready}, {exp_alu, ~exp_alu});
      end
      if (exp_alu) begin
        exp_rd = 5'(1 + ai);  exp_wd = 32'hA000_0000 + 32'(ai); ai++;
      end else begin
        exp_rd = 5'(11 + li); exp_wd = 32'hB000_0000 + 32'(li); li++;
      end
      cyc();
      total++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, exp_rd, exp_wd}) begin
        bad++; $display("FAIL rr_write k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rf_we, rf_a3, rf_wd, exp_rd, exp_wd);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cyc();
  endtask

  task automatic test_rd0();
    rs1_addr = 5'd0; iss_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rd0_alu_ready got=%b exp=1", alu_ready); end
    cyc();
    alu_valid = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_rf_we got=%b exp=0", rf_we); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL rd0_busy got=%b exp=0", rs1_busy); end
    cyc();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_rf_we_later got=%b exp=0", rf_we); end
  endtask

  task automatic test_waw_stall();
    iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd7;
    cyc();
    #1;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b exp=0", iss_ready); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    cyc();
    alu_valid = 1'b0;
    #1;
    total++; if ({rf_we, rf_a3} !== {1'b1, 5'd7}) begin bad++; $display("FAIL waw_retire got=%b/%0d exp=1/7", rf_we, rf_a3); end
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL waw_ready_in_retire got=%b exp=0", iss_ready); end
    cyc();
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL waw_ready_after got=%b exp=1", iss_ready); end
    cyc();
    iss_valid = 1'b0;
    #1;
    total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL waw_rereserve got=%b exp=1", rs1_busy); end
    // Retire the new reservation so x7 is clean again.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0078;
    cyc();
    alu_valid = 1'b0;
    cyc();
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL waw_final_clear got=%b exp=0", rs1_busy); end
  endtask

  task automatic test_set_wins();
    rs2_addr = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
    cyc();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    total++; if ({rf_we, rf_a3} !== {1'b1, 5'd9}) begin bad++; $display("FAIL setwins_retire got=%b/%0d exp=1/9", rf_we, rf_a3); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL setwins_iss_ready got=%b exp=1", iss_ready); end
    cyc();
    iss_valid = 1'b0;
    #1;
    total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL setwins_busy9 got=%b exp=1", rs2_busy); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    cyc();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL rstmid_pre_we got=%b exp=1", rf_we); end
    alu_valid = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd4; iss_rd = 5'd1;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_drop got=%b exp=0", rf_we); end
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy9 got=%b exp=0", rs2_busy); end
    total++; if ({iss_ready, alu_ready, lsu_ready} !== 3'b000) begin
      bad++; $display("FAIL rstmid_readies got=%b exp=000", {iss_ready, alu_ready, lsu_ready});
    end
    cyc();
    total++; if ({rf_we, alu_ready, lsu_ready} !== 3'b000) begin
      bad++; $display("FAIL rstmid_held got=%b exp=000", {rf_we, alu_ready, lsu_ready});
    end
    rst_n = 1'b1;
    #1;
    total++; if ({iss_ready, alu_ready, lsu_ready} !== 3'b110) begin
      bad++; $display("FAIL rstmid_release got=%b exp=110", {iss_ready, alu_ready, lsu_ready});
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_write();
    test_contention();
    test_rd0();
    test_waw_stall();
    test_set_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the 32×32 register file (x0 hardwired to zero; two combinational read ports, one synchronous write port). It shares the single write port between the ALU writeback path and the load/store unit (LSU) return path using a two-way round-robin arbiter. It also keeps a scoreboard of destination registers with writes still outstanding, so issue logic can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file's WE/A3/WD inputs.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Parameters:
  - `XLEN`, 32: data width.
  - `AW`, 5: register address width (2^AW registers).
- Ports:
  - `clk`  in  1  clock; all state updates on the rising edge.
  - `rst_n`  in  1  asynchronous active-low reset.
  - `iss_valid`  in  1  issue stage requests a destination reservation.
  - `iss_rd`  in  AW  destination register to reserve.
  - `iss_ready`  out  1  reservation accepted this cycle.
  - `rs1_addr`, `rs2_addr`  in  AW  source registers to check.
  - `rs1_busy`, `rs2_busy`  out  1  the source has a pending write (combinational).
  - `alu_valid`  in  1  ALU has a write.
  - `alu_rd`  in  AW  ALU destination.
  - `alu_data`  in  XLEN  ALU result.
  - `alu_ready`  out  1  ALU write accepted this cycle.
  - `lsu_valid`  in  1  LSU has a write.
  - `lsu_rd`  in  AW  LSU destination.
  - `lsu_data`  in  XLEN  load data.
  - `lsu_ready`  out  1  LSU write accepted this cycle.
  - `rf_we`  out  1  register file write enable (registered).
  - `rf_a3`  out  AW  register file write address (registered).
  - `rf_wd`  out  XLEN  register file write data (registered).

## Operation
- Scoreboard:
  - Holds `busy[1..31]`; `busy[0]` reads as 0 at all times.
  - `iss_ready = !busy[iss_rd]`, which stalls WAW.
  - A reservation happens when `iss_valid && iss_ready && iss_rd != 0`; that edge sets `busy[iss_rd]`.
  - `rs*_busy = busy[rs*_addr]`.
- Arbitration:
  - The round-robin pointer `rr` is either ALU or LSU.
  - If only one requester is valid, it is granted.
  - If both are valid, the side `rr` points to is granted.
  - After any grant, `rr` moves to the other side.
- Ready signals:
  - `alu_ready = !(lsu_valid && rr==LSU)`.
  - `lsu_ready = !(alu_valid && rr==ALU)`.
  - Neither ready depends on its own requester's valid.
  - A transfer is `valid && ready`.
- Write stage register:
  - On a grant, the next edge loads `rf_we=1`, `rf_a3=rd`, `rf_wd=data`.
  - With no grant, `rf_we=0`; `rf_a3` and `rf_wd` hold their values.
  - A granted write with rd=0 is accepted (ready=1) but loads `rf_we=0`.
- Busy clear:
  - `busy[rf_a3]` clears on the edge where `rf_we=1`, which is the same edge the register file captures the data.
  - If a reservation and a clear hit the same register on the same edge, the set wins.
  - A reservation for a register whose write is in the stage register cannot occur, because `iss_ready=0` while busy.
- Writes to a register that is not busy are legal (untracked writes) and clear nothing spuriously.

## Timing
- Reset values:
  - `busy` all 0.
  - `rr` = ALU.
  - `rf_we=0`, `rf_a3=0`, `rf_wd=0`.
- While `rst_n` is low, `iss_ready`, `alu_ready` and `lsu_ready` are forced to 0.
- Latency:
  - Grant in cycle N gives `rf_we=1` in cycle N+1.
  - The register file is written at the end of N+1.
  - The new value is readable, and `rs_busy` is 0, in N+2.
- Starvation bound: with both sides continuously valid, grants alternate every cycle. No requester waits more than 1 cycle.
- Back-to-back: one write per cycle sustained. The port is never idle while any valid is high.
- Reset asserted mid-operation:
  - State clears immediately.
  - An in-flight `rf_we` drops asynchronously, so no write occurs.
  - Requesters must re-present after reset.

## Structure
- Shared package `regfile_pkg`:
  - `XLEN` and `AW` constants.
  - Requester enum `wb_src_e` {WB_ALU, WB_LSU}.
  - Register index type `reg_idx_t`.
- Sub-module `wb_rr_arb2`: two-way round-robin arbiter with ready generation and the `rr` pointer.
- The scoreboard and write stage register stay in the top module.

## Test plan
- Reset, then issue rd=5 → `busy[5]=1`. ALU writes rd=5, data=0xDEADBEEF → `rf_we=1`, `rf_a3=5`, `rf_wd=0xDEADBEEF` next cycle; `rs1_busy` for x5 is 0 one cycle later.
- ALU and LSU both valid for 4 cycles (ALU rd=1..4, LSU rd=11..14) → grants alternate ALU, LSU, ALU, LSU…; each stalled side holds its data until accepted.
- ALU writes rd=0, data=0x1234 → `alu_ready=1`, `rf_we` stays 0, scoreboard unchanged.
- Issue rd=7 while `busy[7]=1` → `iss_ready=0`. In the cycle its write retires (`rf_we=1`, `rf_a3=7`), `iss_ready` stays 0; one cycle later `iss_ready=1` and the reservation sets `busy[7]` again.
- Issue rd=9 and retire a write to rd=9 on the same edge (via an untracked write path) → `busy[9]=1` after the edge.
- Assert `rst_n=0` while `rf_we=1` → `rf_we=0` immediately, all busy bits 0, readies 0 until release.
